// File: rtl/branch_gshare_if.sv
// branch_gshare_if: prediction and update signals of the gshare predictor.
//   master : fetch / branch unit side (drives requests and updates, receives predictions)
//   slave  : predictor side
//   pred_valid, pred_pc        -> prediction request
//   pred_taken, pred_ctr,
//   pred_ghr                   <- same-cycle prediction and the history snapshot it used
//   upd_valid, upd_pc, upd_ghr,
//   upd_taken, upd_mispredict  -> resolved-branch update
interface branch_gshare_if #(
  parameter int PC_W  = 32,
  parameter int GHR_W = 8
);
  logic             pred_valid;
  logic [PC_W-1:0]  pred_pc;
  logic             pred_taken;
  logic [1:0]       pred_ctr;
  logic [GHR_W-1:0] pred_ghr;
  logic             upd_valid;
  logic [PC_W-1:0]  upd_pc;
  logic [GHR_W-1:0] upd_ghr;
  logic             upd_taken;
  logic             upd_mispredict;

  modport master (
    output pred_valid, pred_pc, upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispredict,
    input  pred_taken, pred_ctr, pred_ghr
  );

  modport slave (
    input  pred_valid, pred_pc, upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispredict,
    output pred_taken, pred_ctr, pred_ghr
  );
endinterface

// File: rtl/branch_gshare.sv
// branch_gshare: gshare direction predictor. A folded PC XOR global history
// indexes a table of 2-bit saturating counters. After reset the table is swept
// to CTR_INIT, one entry per cycle, before ready rises.
//   clk, reset    : clock, synchronous active-high reset
//   ready         : high once the init sweep completes
//   bus (slave)   : prediction port (combinational) and commit-time update port
//   stat_mispred  : saturating count of mispredicted updates
module branch_gshare #(
  parameter int          PC_W      = 32,
  parameter int          GHR_W     = 8,
  parameter int          PHT_IDX_W = 8,
  parameter logic [1:0]  CTR_INIT  = 2'b01,
  parameter int          STAT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ready,
  branch_gshare_if.slave    bus,
  output logic [STAT_W-1:0] stat_mispred
);

  localparam int unsigned DEPTH  = 2 ** PHT_IDX_W;
  localparam int unsigned NCHUNK = (PC_W - 2 + PHT_IDX_W - 1) / PHT_IDX_W;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]           state;
  logic [PHT_IDX_W-1:0] ptr;
  logic [GHR_W-1:0]     ghr;
  logic [1:0]           pht [DEPTH];

  logic [PHT_IDX_W-1:0] pred_idx;
  logic [PHT_IDX_W-1:0] upd_idx;
  logic [1:0]           rd_ctr;
  logic [1:0]           upd_old;
  logic [1:0]           upd_new;
  logic                 taken_int;

  // XOR of PC[PC_W-1:2] in PHT_IDX_W-bit chunks from the LSB, last chunk zero-padded
  function automatic logic [PHT_IDX_W-1:0] fold(input logic [PC_W-3:0] pcw);
    logic [NCHUNK*PHT_IDX_W-1:0] ext;
    logic [PHT_IDX_W-1:0]        acc;
    ext = '0;
    ext[PC_W-3:0] = pcw;
    acc = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) acc ^= ext[i*PHT_IDX_W +: PHT_IDX_W];
    return acc;
  endfunction

  function automatic logic [PHT_IDX_W-1:0] hist_ext(input logic [GHR_W-1:0] h);
    logic [PHT_IDX_W-1:0] r;
    r = '0;
    r[GHR_W-1:0] = h;
    return r;
  endfunction

  assign ready    = (state == ST_READY);
  assign pred_idx = fold(bus.pred_pc[PC_W-1:2]) ^ hist_ext(ghr);
  assign upd_idx  = fold(bus.upd_pc[PC_W-1:2]) ^ hist_ext(bus.upd_ghr);

  // PC byte-offset bits take no part in the hash
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{bus.pred_pc[1:0], bus.upd_pc[1:0]};

  always_comb begin
    rd_ctr       = pht[pred_idx];
    taken_int    = 1'b0;
    bus.pred_ctr = '0;
    bus.pred_ghr = '0;
    if (ready) begin
      bus.pred_ctr = rd_ctr;
      bus.pred_ghr = ghr;
      taken_int    = rd_ctr[1];
    end
    bus.pred_taken = taken_int;
  end

  always_comb begin
    upd_old = pht[upd_idx];
    upd_new = upd_old;
    if (bus.upd_taken) begin
      if (upd_old != 2'b11) upd_new = upd_old + 2'b01;
    end else begin
      if (upd_old != 2'b00) upd_new = upd_old - 2'b01;
    end
  end

  // Single write port: sweep owns it in INIT, updates own it in READY
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_INIT) pht[ptr] <= CTR_INIT;
      else if (bus.upd_valid) pht[upd_idx] <= upd_new;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_INIT;
      ptr          <= '0;
      ghr          <= '0;
      stat_mispred <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          ptr <= ptr + 1'b1;
          if (ptr == '1) state <= ST_READY;
        end
        default: begin
          // Mispredict recovery takes priority over a same-cycle speculative shift
          if (bus.upd_valid && bus.upd_mispredict)
            ghr <= {bus.upd_ghr[GHR_W-2:0], bus.upd_taken};
          else if (bus.pred_valid)
            ghr <= {ghr[GHR_W-2:0], taken_int};
          if (bus.upd_valid && bus.upd_mispredict && (stat_mispred != '1))
            stat_mispred <= stat_mispred + 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_gshare.sv
// tb_branch_gshare: directed bench for branch_gshare. dut0 uses the default
// geometry; dut1 is a small instance with a 2-bit statistics counter.
module tb_branch_gshare;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        ready0;
  logic        ready1;
  logic [15:0] stat0;
  logic [1:0]  stat1;

  branch_gshare_if #(.PC_W(32), .GHR_W(8)) b0 ();
  branch_gshare_if #(.PC_W(32), .GHR_W(4)) b1 ();

  branch_gshare #(.PC_W(32), .GHR_W(8), .PHT_IDX_W(8), .CTR_INIT(2'b01), .STAT_W(16)) dut0 (
    .clk(clk), .reset(reset), .ready(ready0), .bus(b0.slave), .stat_mispred(stat0)
  );

  branch_gshare #(.PC_W(32), .GHR_W(4), .PHT_IDX_W(4), .CTR_INIT(2'b01), .STAT_W(2)) dut1 (
    .clk(clk), .reset(reset), .ready(ready1), .bus(b1.slave), .stat_mispred(stat1)
  );

  int checks = 0;
  int errors = 0;

  logic [1:0]  up_exp [4]  = '{2'b10, 2'b11, 2'b11, 2'b11};
  logic [1:0]  dn_exp [5]  = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
  logic [7:0]  hist   [6]  = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F};
  logic [31:0] pcs    [3]  = '{32'h0000_0040, 32'h1234_5678, 32'hFFFF_FFFC};
  logic [1:0]  st_exp [5]  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready0 && n < 400) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    b0.pred_valid = 1'b0; b0.pred_pc = '0; b0.upd_valid = 1'b0; b0.upd_pc = '0;
    b0.upd_ghr = '0; b0.upd_taken = 1'b0; b0.upd_mispredict = 1'b0;
    b1.pred_valid = 1'b0; b1.pred_pc = '0; b1.upd_valid = 1'b0; b1.upd_pc = '0;
    b1.upd_ghr = '0; b1.upd_taken = 1'b0; b1.upd_mispredict = 1'b0;

    repeat (3) tick();
    chk("rst_ready", ready0, 0);
    chk("rst_stat", stat0, 0);
    chk("rst_ghr", b0.pred_ghr, 0);
    chk("rst_ctr", b0.pred_ctr, 0);

    // Sweep with requests and mispredict updates that must be ignored
    reset = 1'b0;
    b0.pred_valid = 1'b1; b0.pred_pc = 32'h40;
    b0.upd_valid = 1'b1; b0.upd_mispredict = 1'b1; b0.upd_ghr = 8'h05;
    b0.upd_taken = 1'b1; b0.upd_pc = 32'h40;
    repeat (100) tick();
    #1;
    chk("init_ready", ready0, 0);
    chk("init_ctr", b0.pred_ctr, 0);
    chk("init_taken", b0.pred_taken, 0);
    chk("init_ghr", b0.pred_ghr, 0);

    // Reset mid-sweep restarts the full sweep
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_ready(n);
    chk("sweep_len", n, 256);
    b0.pred_valid = 1'b0; b0.upd_valid = 1'b0; b0.upd_mispredict = 1'b0;
    #1;
    chk("ready_high", ready0, 1);
    chk("init_no_stat", stat0, 0);
    chk("init_no_ghr", b0.pred_ghr, 0);

    for (int i = 0; i < 3; i++) begin
      b0.pred_pc = pcs[i];
      #1;
      chk("fresh_ctr", b0.pred_ctr, 2'b01);
      chk("fresh_taken", b0.pred_taken, 0);
    end

    // Saturation at idx 0x10
    b0.pred_pc = 32'h40;
    b0.upd_valid = 1'b1; b0.upd_pc = 32'h40; b0.upd_ghr = 8'h00; b0.upd_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("sat_up", b0.pred_ctr, up_exp[i]);
    end
    b0.upd_taken = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sat_dn", b0.pred_ctr, dn_exp[i]);
    end

    // Prime counters at 0x20 ^ history so six speculative shifts all predict taken
    b0.upd_pc = 32'h80; b0.upd_taken = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b0.upd_ghr = hist[i];
      repeat (2) tick();
    end
    b0.upd_valid = 1'b0;
    b0.pred_valid = 1'b1; b0.pred_pc = 32'h80;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("shift_ghr", b0.pred_ghr, hist[i]);
      chk("shift_taken", b0.pred_taken, 1);
      tick();
    end
    #1;
    chk("shift_final", b0.pred_ghr, 8'h3F);

    // Recovery beats same-cycle speculative shift
    b0.upd_valid = 1'b1; b0.upd_mispredict = 1'b1; b0.upd_ghr = 8'h05;
    b0.upd_taken = 1'b0; b0.upd_pc = 32'h1000;
    tick();
    chk("recover_ghr", b0.pred_ghr, 8'h0A);
    chk("recover_stat", stat0, 1);

    // Back to GHR 0, bring idx 0x10 to 01, then read-before-write
    b0.pred_valid = 1'b0;
    b0.upd_pc = 32'h40; b0.upd_ghr = 8'h00; b0.upd_taken = 1'b0;
    tick();
    chk("clear_ghr", b0.pred_ghr, 0);
    b0.upd_mispredict = 1'b0; b0.upd_taken = 1'b1;
    tick();
    b0.pred_valid = 1'b1; b0.pred_pc = 32'h40;
    #1;
    chk("rbw_old", b0.pred_ctr, 2'b01);
    tick();
    chk("rbw_new", b0.pred_ctr, 2'b10);
    chk("rbw_stat", stat0, 2);
    b0.pred_valid = 1'b0; b0.upd_valid = 1'b0;

    // Saturating 2-bit statistics counter
    b1.upd_valid = 1'b1; b1.upd_mispredict = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stat_sat", stat1, st_exp[i]);
    end
    b1.upd_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_gshare.md
Name: branch_gshare

Overview:
Parametrised gshare direction predictor: the next generation of the fixed 128-entry global predictor. A folded-PC hash XOR a speculative global history register (GHR) indexes a pattern history table (PHT) of 2-bit saturating counters. The block provides a same-cycle prediction port and a commit-time update port with history recovery on mispredict. A post-reset sweep initialises the table. It sits in fetch, beside the BTB, and takes updates from the branch unit at resolve.

Parameters:
PC_W, 32, program counter width
GHR_W, 8, global history length in bits (2..PHT_IDX_W)
PHT_IDX_W, 8, PHT index width; depth = 2**PHT_IDX_W
CTR_INIT, 2'b01, counter value written by the init sweep (weakly not-taken)
STAT_W, 16, width of the mispredict statistics counter

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
ready  out  1  high once the init sweep completes
pred_valid  in  1  fetch requests a prediction this cycle
pred_pc  in  PC_W  PC of the fetched branch
pred_taken  out  1  predicted direction (combinational, same cycle)
pred_ctr  out  2  raw counter value read
pred_ghr  out  GHR_W  GHR snapshot used for this prediction; travels with the branch
upd_valid  in  1  branch resolved/committed
upd_pc  in  PC_W  PC of the resolved branch
upd_ghr  in  GHR_W  snapshot returned from pred_ghr
upd_taken  in  1  actual direction
upd_mispredict  in  1  direction was mispredicted
stat_mispred  out  STAT_W  count of upd_valid & upd_mispredict, saturating

Behaviour:
- States: INIT, READY. Reset forces INIT, sweep pointer = 0, GHR = 0, stat_mispred = 0, ready = 0.
- INIT: writes CTR_INIT to PHT[ptr] once per cycle, ptr += 1. After writing entry 2**PHT_IDX_W-1, moves to READY the next cycle. The sweep takes exactly 2**PHT_IDX_W cycles after reset deasserts. Reset asserted mid-sweep restarts at ptr 0.
- In INIT:
  - pred_taken = 0 and pred_ctr = 0.
  - pred_valid is ignored; GHR does not shift.
  - upd_valid is ignored (no PHT write, no GHR change, no stat increment).
- Hash:
  - fold = XOR of PC[PC_W-1:2] split into PHT_IDX_W-bit chunks from the LSB; the last chunk is zero-padded.
  - idx = fold ^ zero-extended GHR.
  - The prediction uses pred_pc and the live GHR. The update uses upd_pc and upd_ghr, never the live GHR.
- Predict (READY):
  - pred_ctr = PHT[idx], pred_taken = pred_ctr[1], pred_ghr = live GHR. All are combinational in the same cycle.
  - If pred_valid: GHR <= {GHR[GHR_W-2:0], pred_taken} at the edge.
  - Outputs are driven even when pred_valid is low. pred_ghr/pred_ctr read 0 only in reset/INIT.
- Update (READY, upd_valid):
  - The counter at the upd index saturates: taken increments (max 3), not-taken decrements (min 0). It is written at the edge.
  - If upd_mispredict: GHR <= {upd_ghr[GHR_W-2:0], upd_taken}. This recovery has priority over a same-cycle prediction shift.
  - stat_mispred increments and holds at all-ones.
- Simultaneous predict/update to the same index: the prediction sees the old value (read-before-write). The new value is visible from the next cycle.
- Single write port: the only write sources are the sweep (INIT) and update (READY), so they never collide.

Test Plan:
- Reset held 3 cycles, then released → ready = 0 for 256 cycles and rises on cycle 257. Any pred_pc gives pred_ctr = 2'b01, pred_taken = 0. Pulse reset at sweep cycle 100 → the full 256-cycle sweep restarts.
- pred_pc = 0x0000_0040, GHR = 0 (idx 0x10): four updates taken with upd_ghr = 0 → pred_ctr goes 01→10→11→11 (saturates). Five not-taken updates → 00, holding at 00.
- Six pred_valid cycles on an index whose counter is 11 → GHR goes 0x00→0x01→0x03→…→0x3F, and pred_ghr shows the pre-shift value each cycle.
- GHR = 0x3F, upd_valid & upd_mispredict with upd_ghr = 0x05, upd_taken = 0, and pred_valid in the same cycle → next GHR = 0x0A (recovery wins), stat_mispred = 1.
- Predict and update to idx 0x10 (counter 01, update taken) in the same cycle → pred_ctr = 01 this cycle, 10 next cycle.
- STAT_W = 2, five mispredict updates → stat_mispred goes 1, 2, 3, 3, 3.
